// File: rtl/sub_pkg.sv
`default_nettype none
// ===========================================================================
// sub_pkg : shared state encoding and width limit for the serial subtractor
// Revision: 1.0
// ===========================================================================
package sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int MAX_WIDTH = 32;

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ===========================================================================
// full_subtractor : one-bit a - b - bin from two half subtractors
// Revision: 1.0
// ===========================================================================
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs_ab (
    .a    (a),
    .b    (b),
    .d    (d1),
    .bout (b1)
  );

  half_subtractor u_hs_bin (
    .a    (d1),
    .b    (bin),
    .d    (d),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule
`default_nettype wire

// File: rtl/half_subtractor.sv
`default_nettype none
// ===========================================================================
// half_subtractor : one-bit a - b with borrow out
// Revision: 1.0
// ===========================================================================
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  assign d    = a ^ b;
  assign bout = ~a & b;

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ===========================================================================
// serial_subtractor : bit-serial unsigned a - b, LSB first, start/done handshake
// Revision: 1.0
// ===========================================================================
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_subtractor: WIDTH out of range");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] a_sr_next;
  logic             accept;
  logic             last_shift;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // The minuend register doubles as the result register: each consumed
  // minuend bit at the bottom frees a slot at the top for a difference bit.
  if (WIDTH == 1) begin : g_w1
    assign a_sr_next = fs_d;
  end else begin : g_wn
    assign a_sr_next = {fs_d, a_sr_q[WIDTH-1:1]};
  end

  assign accept     = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_shift = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_d = ST_DONE;
      ST_DONE:  state_d = accept ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_SHIFT);
    done       = (state_q == ST_DONE);
    diff       = diff_q;
    borrow_out = bout_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    a_sr_d = a_sr_q;
    b_sr_d = b_sr_q;
    bin_d  = bin_q;
    diff_d = diff_q;
    bout_d = bout_q;
    if (accept) begin
      a_sr_d = a;
      b_sr_d = b;
      bin_d  = 1'b0;
      cnt_d  = '0;
    end else if (state_q == ST_SHIFT) begin
      a_sr_d = a_sr_next;
      b_sr_d = b_sr_q >> 1;
      bin_d  = fs_bout;
      cnt_d  = cnt_q + CNT_W'(1);
      if (last_shift) begin
        diff_d = a_sr_next;
        bout_d = fs_bout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_sr_q <= '0;
      b_sr_q <= '0;
      bin_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      bin_q  <= bin_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ===========================================================================
// tb_serial_subtractor : directed vectors for the 8-bit and 1-bit subtractor
// Revision: 1.0
// ===========================================================================
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       bo1;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (bo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
    logic       b2b;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start is held for exactly one edge; operands are scrambled afterwards.
  task automatic issue(input logic [7:0] va, input logic [7:0] vb);
    a     = va;
    b     = vb;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  task automatic wait_done(input string name, input int exp_lat,
                           input logic [7:0] exp_d, input logic exp_bo);
    int lat = 0;
    int busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      step();
      lat++;
    end
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(busy_cycles), 32'(exp_lat));
    check({name, " busy in done"}, 32'(busy), 32'd0);
    check({name, " diff"}, 32'(diff), 32'(exp_d));
    check({name, " borrow"}, 32'(exp_bo), 32'(borrow_out));
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    step();
    step();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].b2b) begin
        step();
        check($sformatf("vec%0d idle done low", i), 32'(done), 32'd0);
      end
      issue(vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d busy after start", i), 32'(busy), 32'd1);
      wait_done($sformatf("vec%0d", i), 8, vecs[i].d, vecs[i].bo);
    end
    step();
    check("tail done pulse ends", 32'(done), 32'd0);

    // Start pulse in the middle of SHIFT must not disturb the running op.
    step();
    issue(8'h10, 8'h01);
    step();
    step();
    a     = 8'h77;
    b     = 8'h11;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ignored start", 5, 8'h0F, 1'b0);
    step();
    check("ignored start single pulse", 32'(done), 32'd0);
    step();
    check("diff holds in idle", 32'(diff), 32'h0F);

    // Asynchronous reset in the middle of an operation.
    issue(8'hC3, 8'h3C);
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset diff", 32'(diff), 32'd0);
    check("midreset borrow", 32'(borrow_out), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (i == 2) begin
          @(negedge clk);
          rst_n = 1'b1;
        end
        step();
        if (done) seen++;
      end
      check("midreset no done", 32'(seen), 32'd0);
    end
    issue(8'h09, 8'h04);
    wait_done("after reset", 8, 8'h05, 1'b0);
    step();

    // One-bit instance: every operand pair.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      logic       ed;
      logic       eb;
      ab = 2'(i);
      ed = ab[1] ^ ab[0];
      eb = ~ab[1] & ab[0];
      a1     = ab[1];
      b1     = ab[0];
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      a1     = ~a1;
      b1     = ~b1;
      check($sformatf("w1 %0b%0b busy", ab[1], ab[0]), 32'(busy1), 32'd1);
      check($sformatf("w1 %0b%0b early done", ab[1], ab[0]), 32'(done1), 32'd0);
      step();
      check($sformatf("w1 %0b%0b done", ab[1], ab[0]), 32'(done1), 32'd1);
      check($sformatf("w1 %0b%0b diff", ab[1], ab[0]), 32'(diff1), 32'(ed));
      check($sformatf("w1 %0b%0b borrow", ab[1], ab[0]), 32'(bo1), 32'(eb));
      step();
      check($sformatf("w1 %0b%0b done ends", ab[1], ab[0]), 32'(done1), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
